siso_sched: RTL and testbench
=============================

# siso_sched

Block scheduler for the SISO decoder. It accepts the interleaved systematic/parity sample stream and the a-priori stream for one block of `blklen` trellis steps and writes them into the external step buffer. It then sequences the forward (alpha) read pass and the backward (beta) read pass over that buffer for the branch-metric/recursion datapath, and signals block completion. It sits between the input interface and the branch-metric unit, replacing free-running input counters.

## Interface
- `DATA_W`, 16, sample and a-priori width (signed two's complement, passed through untouched)
- `ADDR_W`, 9, step-buffer address width; maximum block is 2**ADDR_W steps
- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: reset, asynchronous, active-low; clears all state and outputs
- `blklen` in ADDR_W+1: block length in trellis steps, sampled on the first accepted input of a block
- `in` in DATA_W: input sample; even samples are systematic, odd samples are parity
- `valid_in` in 1: `in` is valid this cycle
- `apriori` in DATA_W: a-priori LLR, one per step
- `valid_apriori` in 1: `apriori` is valid this cycle
- `in_ready` out 1: high in IDLE and LOAD
- `wr_in_en` out 1: write strobe for a step pair
- `wr_in_addr` out ADDR_W: step index for the pair write
- `wr_in_data` out 2*DATA_W: {parity, systematic}
- `wr_apr_en` out 1: write strobe for an a-priori value
- `wr_apr_addr` out ADDR_W: step index for the a-priori write
- `wr_apr_data` out DATA_W: a-priori value
- `rd_en` out 1: step-buffer read strobe
- `rd_addr` out ADDR_W: step index being read
- `rd_dir` out 1: 0 = forward pass, 1 = backward pass
- `rd_first` out 1: first read of the current pass
- `rd_last` out 1: last read of the current pass
- `busy` out 1: a block is in progress
- `done` out 1: one-cycle pulse at the end of a block
- `err` out 1: sticky protocol error; cleared when the next block starts

## Operation
- States are IDLE → LOAD → FWD → BWD → IDLE.
- **IDLE.** The first cycle with `valid_in` or `valid_apriori` latches `blklen` as L.
  - If L = 0 or L > 2**ADDR_W: set `err`, drop the sample, stay in IDLE.
  - Otherwise: clear `err`, go to LOAD, and count that sample as accepted.
- **LOAD, pair side.**
  - Sample counter s counts 0..2L-1.
  - On an even s, the sample is held as systematic.
  - On an odd s, the pair is written to step (s-1)/2.
- **LOAD, a-priori side.**
  - Counter a counts 0..L-1.
  - Each accepted a-priori value is written to step a.
- **Stream independence.** The two streams are independent; any skew between them is allowed. Simultaneous `valid_in` and `valid_apriori` are both accepted.
- **Excess samples in LOAD.** A sample arriving on a stream whose counter is already full is dropped and sets `err`.
- **Leaving LOAD.** LOAD ends when s = 2L and a = L.
- **FWD.** Reads steps 0..L-1 with `rd_dir`=0.
- **BWD.** Reads steps L-1..0 with `rd_dir`=1, starting the cycle after the last FWD read.
- **Inputs outside IDLE/LOAD.** Any valid input during FWD or BWD is dropped and sets `err`.
- **L = 1.** `rd_first` and `rd_last` are both high on the single read of each pass.
- **Address widths.** Counters are ADDR_W+1 bits wide, so no counter wraps at L = 2**ADDR_W.
- **Reset mid-block.** Abandons the block with no `done` pulse.

## Timing
- **Reset values.** All outputs are 0, except `in_ready`=1.
- **Write latency.** A write strobe rises 1 cycle after the accepting edge. `wr_*_en` are single-cycle pulses.
- **Gap before reading.** The first FWD `rd_en` is asserted 1 cycle after the last `wr_*_en` cycle, so no read ever shares a cycle with a write.
- **Pass length.** `rd_en` stays high for exactly 2L consecutive cycles (FWD then BWD, with no gap).
- **Read sideband.** `rd_addr`, `rd_dir`, `rd_first` and `rd_last` are registered and valid only while `rd_en` is high.
- **`busy`.** High from the cycle after the first accepted sample through the last BWD read cycle.
- **`done`.** Pulses in the cycle immediately after the last BWD read. In that same cycle `in_ready`=1, and a new block may begin on that cycle's edge.

## Test plan
- **Nominal block.** L=4; `in`=1..8 on consecutive cycles; `apriori`=10..13 on every other cycle.
  - Pair writes: (0,{2,1}), (1,{4,3}), (2,{6,5}), (3,{8,7}).
  - A-priori writes: 0..3 → 10..13.
  - Reads: addresses 0,1,2,3 (dir 0) then 3,2,1,0 (dir 1), 8 cycles.
  - `rd_first` at 0 and at the first 3; `rd_last` at the first 3 and at 0.
  - `done` follows the final read; `err`=0.
- **A-priori lag.** All 8 `in` samples arrive first, then 4 a-priori values.
  - The FWD pass starts 2 cycles after the last a-priori edge.
  - Contents are identical to the nominal block.
- **Invalid length.** `blklen`=0 with `valid_in`: `err`=1, state stays IDLE, no writes. A following block with L=2 clears `err` and completes normally.
- **Overrun.** L=2 with 5 `in` samples: the 5th is dropped, `err`=1, exactly 2 pair writes occur, and the block completes.
- **Maximum length.** L=512: reads run 0..511 then 511..0; `done` arrives exactly 1024 cycles after the first read.
- **Reset mid-block.** `rst` low during the FWD pass at step 2: all outputs drop to reset values immediately; there is no `done`. After release, a new L=1 block gives reads 0 (dir 0) then 0 (dir 1), each with `rd_first`=`rd_last`=1.

Source files
------------

// File: rtl/siso_sched.sv
// Block scheduler for the SISO decoder: loads one block of step pairs and a-priori
// values into the step buffer, then sequences a forward and a backward read pass.
module siso_sched #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W:0]     blklen,
   input  logic [DATA_W-1:0]   in,
   input  logic                valid_in,
   input  logic [DATA_W-1:0]   apriori,
   input  logic                valid_apriori,
   output logic                in_ready,
   output logic                wr_in_en,
   output logic [ADDR_W-1:0]   wr_in_addr,
   output logic [2*DATA_W-1:0] wr_in_data,
   output logic                wr_apr_en,
   output logic [ADDR_W-1:0]   wr_apr_addr,
   output logic [DATA_W-1:0]   wr_apr_data,
   output logic                rd_en,
   output logic [ADDR_W-1:0]   rd_addr,
   output logic                rd_dir,
   output logic                rd_first,
   output logic                rd_last,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          dbg_state_o
);

   // Handshake: a stream sample transfers on any rising edge where its valid is high,
   // in_ready is high and that stream's counter is not yet full; any other valid
   // sample is dropped and raises err. There is no back-pressure beyond in_ready.

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FWD = 2'd2, BWD = 2'd3} state_t;

   localparam logic [ADDR_W:0] MAX_L = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] TWO   = {{(ADDR_W-1){1'b0}}, 2'b10};

   state_t              state_q;
   logic [ADDR_W:0]     len_q;
   logic [ADDR_W:0]     pair_q;
   logic                phase_q;
   logic [ADDR_W:0]     apr_cnt_q;
   logic [DATA_W-1:0]   sys_q;
   logic                in_ready_q;
   logic                wr_in_en_q;
   logic [ADDR_W-1:0]   wr_in_addr_q;
   logic [2*DATA_W-1:0] wr_in_data_q;
   logic                wr_apr_en_q;
   logic [ADDR_W-1:0]   wr_apr_addr_q;
   logic [DATA_W-1:0]   wr_apr_data_q;
   logic                rd_en_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                rd_dir_q;
   logic                rd_first_q;
   logic                rd_last_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;

   logic len_bad;
   logic in_full;
   logic apr_full;

   assign len_bad  = (blklen == '0) || (blklen > MAX_L);
   // pair_q only advances on the parity half, so "full" implies no systematic is held.
   assign in_full  = (pair_q == len_q);
   assign apr_full = (apr_cnt_q == len_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         len_q         <= '0;
         pair_q        <= '0;
         phase_q       <= 1'b0;
         apr_cnt_q     <= '0;
         sys_q         <= '0;
         in_ready_q    <= 1'b1;
         wr_in_en_q    <= 1'b0;
         wr_in_addr_q  <= '0;
         wr_in_data_q  <= '0;
         wr_apr_en_q   <= 1'b0;
         wr_apr_addr_q <= '0;
         wr_apr_data_q <= '0;
         rd_en_q       <= 1'b0;
         rd_addr_q     <= '0;
         rd_dir_q      <= 1'b0;
         rd_first_q    <= 1'b0;
         rd_last_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         wr_in_en_q  <= 1'b0;
         wr_apr_en_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_in || valid_apriori) begin
                  if (len_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     err_q     <= 1'b0;
                     len_q     <= blklen;
                     busy_q    <= 1'b1;
                     state_q   <= LOAD;
                     pair_q    <= '0;
                     phase_q   <= valid_in;
                     apr_cnt_q <= valid_apriori ? ONE : '0;
                     if (valid_in) sys_q <= in;
                     if (valid_apriori) begin
                        wr_apr_en_q   <= 1'b1;
                        wr_apr_addr_q <= '0;
                        wr_apr_data_q <= apriori;
                     end
                  end
               end
            end
            LOAD: begin
               if (valid_in) begin
                  if (in_full) begin
                     err_q <= 1'b1;
                  end else if (!phase_q) begin
                     sys_q   <= in;
                     phase_q <= 1'b1;
                  end else begin
                     wr_in_en_q   <= 1'b1;
                     wr_in_addr_q <= pair_q[ADDR_W-1:0];
                     wr_in_data_q <= {in, sys_q};
                     pair_q       <= pair_q + 1'b1;
                     phase_q      <= 1'b0;
                  end
               end
               if (valid_apriori) begin
                  if (apr_full) begin
                     err_q <= 1'b1;
                  end else begin
                     wr_apr_en_q   <= 1'b1;
                     wr_apr_addr_q <= apr_cnt_q[ADDR_W-1:0];
                     wr_apr_data_q <= apriori;
                     apr_cnt_q     <= apr_cnt_q + 1'b1;
                  end
               end
               // Full counters are seen one edge after the last write was issued,
               // which leaves the write cycle free of reads.
               if (in_full && apr_full) begin
                  state_q    <= FWD;
                  in_ready_q <= 1'b0;
                  rd_en_q    <= 1'b1;
                  rd_addr_q  <= '0;
                  rd_dir_q   <= 1'b0;
                  rd_first_q <= 1'b1;
                  rd_last_q  <= (len_q == ONE);
               end
            end
            FWD: begin
               if (valid_in || valid_apriori) err_q <= 1'b1;
               if (rd_last_q) begin
                  state_q    <= BWD;
                  rd_dir_q   <= 1'b1;
                  rd_addr_q  <= ADDR_W'(len_q - 1'b1);
                  rd_first_q <= 1'b1;
                  rd_last_q  <= (len_q == ONE);
               end else begin
                  rd_addr_q  <= rd_addr_q + 1'b1;
                  rd_first_q <= 1'b0;
                  rd_last_q  <= (({1'b0, rd_addr_q} + TWO) == len_q);
               end
            end
            BWD: begin
               if (valid_in || valid_apriori) err_q <= 1'b1;
               if (rd_last_q) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
                  rd_en_q    <= 1'b0;
                  rd_addr_q  <= '0;
                  rd_dir_q   <= 1'b0;
                  rd_first_q <= 1'b0;
                  rd_last_q  <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
               end else begin
                  rd_addr_q  <= rd_addr_q - 1'b1;
                  rd_first_q <= 1'b0;
                  rd_last_q  <= (rd_addr_q == ADDR_W'(1));
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign wr_in_en    = wr_in_en_q;
   assign wr_in_addr  = wr_in_addr_q;
   assign wr_in_data  = wr_in_data_q;
   assign wr_apr_en   = wr_apr_en_q;
   assign wr_apr_addr = wr_apr_addr_q;
   assign wr_apr_data = wr_apr_data_q;
   assign rd_en       = rd_en_q;
   assign rd_addr     = rd_addr_q;
   assign rd_dir      = rd_dir_q;
   assign rd_first    = rd_first_q;
   assign rd_last     = rd_last_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_siso_sched.sv
// Self-checking bench for siso_sched: a timeline model predicts every strobe,
// address, data word and status flag per cycle from the stimulus schedule.
module tb_siso_sched;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 9;
   localparam int BIG    = 1000000000;
   localparam int WR_W   = 32 + ADDR_W + 2*DATA_W;
   localparam int AP_W   = 32 + ADDR_W + DATA_W;
   localparam int RD_W   = ADDR_W + 3;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W:0]     blklen = '0;
   logic [DATA_W-1:0]   in = '0;
   logic                valid_in = 1'b0;
   logic [DATA_W-1:0]   apriori = '0;
   logic                valid_apriori = 1'b0;
   logic                in_ready, wr_in_en, wr_apr_en, rd_en, rd_dir, rd_first, rd_last;
   logic                busy, done, err;
   logic [ADDR_W-1:0]   wr_in_addr, wr_apr_addr, rd_addr;
   logic [2*DATA_W-1:0] wr_in_data;
   logic [DATA_W-1:0]   wr_apr_data;
   logic [1:0]          dbg_state_o;

   siso_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .blklen(blklen), .in(in), .valid_in(valid_in),
      .apriori(apriori), .valid_apriori(valid_apriori), .in_ready(in_ready),
      .wr_in_en(wr_in_en), .wr_in_addr(wr_in_addr), .wr_in_data(wr_in_data),
      .wr_apr_en(wr_apr_en), .wr_apr_addr(wr_apr_addr), .wr_apr_data(wr_apr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_dir(rd_dir), .rd_first(rd_first),
      .rd_last(rd_last), .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state_o)
   );

   // scoreboard / model state
   logic [WR_W-1:0] wr_q[$];
   logic [AP_W-1:0] ap_q[$];
   logic [RD_W-1:0] rd_q[$];
   logic [32:0]     err_q[$];
   logic            exp_err = 1'b0;
   int busy_from = BIG, rd_start = BIG, rd_len = 0;
   int n_cmp = 0, n_bad = 0, n_done = 0, exp_n_done = 0;
   int done_cyc = 0, rd_rise_cyc = 0;
   logic rd_en_prev = 1'b0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_flags"}, {wr_in_en, wr_apr_en, rd_en, rd_dir, rd_first, rd_last, busy, done, err}, 0);
      chk({tag, "_addrs"}, {wr_in_addr, wr_apr_addr, rd_addr}, 0);
      chk({tag, "_data"}, {wr_in_data, wr_apr_data}, 0);
      chk({tag, "_state"}, dbg_state_o, 0);
   endtask

   task automatic compare_cycle();
      bit e_rd, e_done, e_busy, e_wi, e_wa;
      int e_state;
      logic [WR_W-1:0] w;
      logic [AP_W-1:0] a;
      logic [RD_W-1:0] r;
      while (err_q.size() > 0 && int'(err_q[0][32:1]) <= cyc) begin
         exp_err = err_q[0][0];
         void'(err_q.pop_front());
      end
      e_rd   = (cyc >= rd_start) && (cyc < rd_start + rd_len);
      e_done = (cyc == rd_start + rd_len);
      e_busy = (cyc >= busy_from) && (cyc < rd_start + rd_len);
      if (e_rd) e_state = (cyc < rd_start + rd_len/2) ? 2 : 3;
      else if (e_busy) e_state = 1;
      else e_state = 0;
      chk("rd_en", rd_en, e_rd);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("in_ready", in_ready, e_state < 2);
      chk("state", dbg_state_o, e_state);
      chk("err", err, exp_err);
      e_wi = 1'b0;
      if (wr_q.size() > 0) begin
         w = wr_q[0];
         e_wi = (int'(w[WR_W-1 -: 32]) == cyc);
      end
      chk("wr_in_en", wr_in_en, e_wi);
      if (e_wi) begin
         chk("wr_in_addr", wr_in_addr, w[2*DATA_W+ADDR_W-1 -: ADDR_W]);
         chk("wr_in_data", wr_in_data, w[2*DATA_W-1:0]);
         void'(wr_q.pop_front());
      end
      e_wa = 1'b0;
      if (ap_q.size() > 0) begin
         a = ap_q[0];
         e_wa = (int'(a[AP_W-1 -: 32]) == cyc);
      end
      chk("wr_apr_en", wr_apr_en, e_wa);
      if (e_wa) begin
         chk("wr_apr_addr", wr_apr_addr, a[DATA_W+ADDR_W-1 -: ADDR_W]);
         chk("wr_apr_data", wr_apr_data, a[DATA_W-1:0]);
         void'(ap_q.pop_front());
      end
      if (e_rd) begin
         if (rd_q.size() == 0) chk("rd_q_empty", 1, 0);
         else begin
            r = rd_q.pop_front();
            chk("rd_addr", rd_addr, r[RD_W-1:3]);
            chk("rd_dir", rd_dir, r[2]);
            chk("rd_first", rd_first, r[1]);
            chk("rd_last", rd_last, r[0]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         done_cyc = cyc;
         n_done++;
      end
      if (rd_en && !rd_en_prev) rd_rise_cyc = cyc;
      rd_en_prev = rd_en;
      if (chk_en) compare_cycle();
   end

   // driver: builds a schedule, loads the model, drives it, then waits or aborts
   task automatic run_block(input int blk, input int n_in, input int n_apr, input int mode,
                            input int pin, input int abort_step);
      int off_in[$], off_apr[$];
      logic [DATA_W-1:0] d_in[$], d_apr[$];
      logic [WR_W-1:0] w;
      logic [AP_W-1:0] a;
      int t, n_t, base, f, last, xs, pi, pa, L;
      bit ok, vi, va;
      t = 0;
      while (off_in.size() < n_in || off_apr.size() < n_apr) begin
         case (mode)
            0: begin
               vi = off_in.size() < n_in;
               va = (off_apr.size() < n_apr) && (t % 2 == 0);
            end
            1: begin
               vi = off_in.size() < n_in;
               va = !vi && (off_apr.size() < n_apr);
            end
            default: begin
               vi = (off_in.size() < n_in) && ($urandom_range(0, 3) != 0);
               va = (off_apr.size() < n_apr) && ($urandom_range(0, 2) != 0);
            end
         endcase
         if (vi) begin
            off_in.push_back(t);
            d_in.push_back(mode < 2 ? DATA_W'(off_in.size()) : DATA_W'($urandom));
         end
         if (va) begin
            off_apr.push_back(t);
            d_apr.push_back(mode < 2 ? DATA_W'(9 + off_apr.size()) : DATA_W'($urandom));
         end
         t++;
      end
      n_t = t;
      @(posedge clk); #1;
      base = cyc;
      L = blk;
      ok = (blk >= 1) && (blk <= (1 << ADDR_W));
      f = BIG;
      if (off_in.size() > 0) f = off_in[0];
      if (off_apr.size() > 0 && off_apr[0] < f) f = off_apr[0];
      if (!ok) err_q.push_back({32'(base + f + 1), 1'b1});
      else begin
         for (int i = 0; i < L; i++) begin
            wr_q.push_back({32'(base + off_in[2*i+1] + 1), ADDR_W'(i), d_in[2*i+1], d_in[2*i]});
            ap_q.push_back({32'(base + off_apr[i] + 1), ADDR_W'(i), d_apr[i]});
         end
         for (int i = 0; i < L; i++) rd_q.push_back({ADDR_W'(i), 1'b0, i == 0, i == L - 1});
         for (int i = L - 1; i >= 0; i--) rd_q.push_back({ADDR_W'(i), 1'b1, i == L - 1, i == 0});
         last = (off_in[2*L-1] > off_apr[L-1]) ? off_in[2*L-1] : off_apr[L-1];
         busy_from = base + f + 1;
         rd_start  = base + last + 2;
         rd_len    = 2 * L;
         err_q.push_back({32'(busy_from), 1'b0});
         xs = BIG;
         if (n_in > 2*L) xs = off_in[2*L];
         if (n_apr > L && off_apr[L] < xs) xs = off_apr[L];
         if (xs != BIG) err_q.push_back({32'(base + xs + 1), 1'b1});
         if (abort_step < 0) exp_n_done++;
      end
      // hand-computed pins on the model itself
      if (pin == 1) begin
         chk("pin_nom_rd_offset", rd_start - base, 9);
         w = wr_q[3];
         chk("pin_nom_pair3", {w[2*DATA_W+ADDR_W-1 -: ADDR_W], w[2*DATA_W-1:0]}, {9'd3, 16'd8, 16'd7});
         a = ap_q[3];
         chk("pin_nom_apr3", a[DATA_W-1:0], 13);
         chk("pin_nom_rd4", rd_q[4], {9'd3, 3'b110});
      end
      if (pin == 2) chk("pin_lag_rd_offset", rd_start - base, 13);
      if (pin == 3) begin
         chk("pin_l1_fwd", rd_q[0], {9'd0, 3'b011});
         chk("pin_l1_bwd", rd_q[1], {9'd0, 3'b111});
      end
      if (pin == 4) chk("pin_max_rd_len", rd_len, 1024);
      blklen = (ADDR_W+1)'(blk);
      pi = 0;
      pa = 0;
      for (int k = 0; k < n_t; k++) begin
         valid_in = (pi < off_in.size()) && (off_in[pi] == k);
         if (valid_in) begin in = d_in[pi]; pi++; end
         valid_apriori = (pa < off_apr.size()) && (off_apr[pa] == k);
         if (valid_apriori) begin apriori = d_apr[pa]; pa++; end
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
      valid_apriori = 1'b0;
      if (!ok) begin
         repeat (3) @(posedge clk);
         #1;
      end else if (abort_step < 0) begin
         while (cyc <= rd_start + rd_len) begin @(posedge clk); #1; end
         @(negedge clk); #1;
         chk("wr_q_left", wr_q.size(), 0);
         chk("ap_q_left", ap_q.size(), 0);
         chk("rd_q_left", rd_q.size(), 0);
         chk("n_done", n_done, exp_n_done);
      end else begin
         while (cyc < rd_start + abort_step) begin @(posedge clk); #1; end
         @(negedge clk); #1;
         chk_en = 1'b0;
         rst = 1'b0;
         #1;
         check_reset_vals("mid");
         wr_q.delete(); ap_q.delete(); rd_q.delete(); err_q.delete();
         exp_err = 1'b0;
         rd_start = BIG; busy_from = BIG; rd_len = 0;
         repeat (3) @(posedge clk);
         #1;
         rst = 1'b1;
         @(negedge clk); #1;
         chk("no_done_after_reset", n_done, exp_n_done);
         chk_en = 1'b1;
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      #2 check_reset_vals("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk_en = 1'b1;
      run_block(4, 8, 4, 0, 1, -1);
      run_block(4, 8, 4, 1, 2, -1);
      run_block(0, 1, 0, 0, 0, -1);
      run_block(513, 0, 1, 0, 0, -1);
      run_block(2, 4, 2, 0, 0, -1);
      run_block(2, 5, 2, 0, 0, -1);
      for (int k = 0; k < 8; k++) begin
         int ln;
         ln = $urandom_range(1, 16);
         run_block(ln, 2*ln, ln, 2, 0, -1);
      end
      run_block(512, 1024, 512, 2, 4, -1);
      chk("max_done_gap", done_cyc - rd_rise_cyc, 1024);
      run_block(4, 8, 4, 0, 0, 2);
      run_block(1, 2, 1, 0, 3, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
